// File: rtl/ring_counter_pkg.sv
// Shared constants for the multimode ring/Johnson counter.
// Mode and direction encodings used by the counter and its legality checker.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_RIGHT    = 1'b0;
  localparam logic DIR_LEFT     = 1'b1;

endpackage : ring_counter_pkg

// File: rtl/ring_state_check.sv
// Combinational legality detector for ring (one-hot) and Johnson (edge-anchored
// run of ones, including all-zeros and all-ones) counter states.
module ring_state_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  output logic             legal
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic ring_legal;
  logic johnson_legal;

  assign ring_legal = (state != '0) && ((state & (state - 1'b1)) == '0);

  // A legal Johnson state is all-ones shifted fully or partly off either end.
  always_comb begin
    johnson_legal = 1'b0;
    for (int k = 0; k <= WIDTH; k++) begin
      if ((state == (ONES << k)) || (state == (ONES >> k))) begin
        johnson_legal = 1'b1;
      end
    end
  end

  assign legal = (mode == MODE_JOHNSON) ? johnson_legal : ring_legal;

endmodule : ring_state_check

// File: rtl/multimode_ring_counter.sv
// Ring / Johnson counter with direction control, parallel load and
// illegal-state detection with optional self-correction to the home value.
module multimode_ring_counter
  import ring_counter_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] step_val;
  logic             feed_right;
  logic             feed_left;
  logic             legal;

  assign home = (mode == MODE_JOHNSON) ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};

  // Johnson mode inverts the bit wrapping around the end; ring mode passes it.
  assign feed_right = (mode == MODE_JOHNSON) ? ~count[0]       : count[0];
  assign feed_left  = (mode == MODE_JOHNSON) ? ~count[WIDTH-1] : count[WIDTH-1];

  assign step_val = (dir == DIR_LEFT) ? {count[WIDTH-2:0], feed_left}
                                      : {feed_right, count[WIDTH-1:1]};

  ring_state_check #(
    .WIDTH(WIDTH)
  ) u_check (
    .state(count),
    .mode (mode),
    .legal(legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= home;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (en) begin
      if (!legal) begin
        count <= SELF_CORRECT ? home : step_val;
        wrap  <= 1'b0;
        err   <= 1'b1;
      end else begin
        count <= step_val;
        wrap  <= (step_val == home);
        err   <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end
  end

endmodule : multimode_ring_counter

// File: tb/tb_multimode_ring_counter.sv
// Directed bench for multimode_ring_counter: a self-correcting instance and a
// flag-only instance share one stimulus stream.
module tb_multimode_ring_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       wrap;
  logic       err;
  logic [3:0] countNc;
  logic       wrapNc;
  logic       errNc;

  int vectorCount = 0;
  int missCount   = 0;

  multimode_ring_counter #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val),
    .count(count), .wrap(wrap), .err(err)
  );

  multimode_ring_counter #(.WIDTH(4), .SELF_CORRECT(1'b0)) dutNc (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val),
    .count(countNc), .wrap(wrapNc), .err(errNc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic l, input logic e,
                               input logic m, input logic d, input logic [3:0] lv);
    rst      = r;
    load     = l;
    en       = e;
    mode     = m;
    dir      = d;
    load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectorCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkMain(input string tag, input logic [3:0] c, input logic w, input logic e);
    checkOutput({tag, ".count"}, count, c);
    checkOutput({tag, ".wrap"}, {3'b0, wrap}, {3'b0, w});
    checkOutput({tag, ".err"}, {3'b0, err}, {3'b0, e});
  endtask

  task automatic checkNc(input string tag, input logic [3:0] c, input logic w, input logic e);
    checkOutput({tag, ".nc.count"}, countNc, c);
    checkOutput({tag, ".nc.wrap"}, {3'b0, wrapNc}, {3'b0, w});
    checkOutput({tag, ".nc.err"}, {3'b0, errNc}, {3'b0, e});
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load_val = '0;
    @(negedge clk);

    // Ring, shifting right from reset
    applyStimulus(1, 0, 0, 0, 0, 4'b0000); checkMain("ring_rst", 4'b0001, 0, 0);
    checkNc("ring_rst", 4'b0001, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 4'b0000); checkMain("ringR1", 4'b1000, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 4'b0000); checkMain("ringR2", 4'b0100, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 4'b0000); checkMain("ringR3", 4'b0010, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 4'b0000); checkMain("ringR4", 4'b0001, 1, 0);

    // Ring left with a hold in the middle
    applyStimulus(0, 0, 1, 0, 1, 4'b0000); checkMain("ringL1", 4'b0010, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 4'b0000); checkMain("ringHold", 4'b0010, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 4'b0000); checkMain("ringL2", 4'b0100, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 4'b0000); checkMain("ringL3", 4'b1000, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 4'b0000); checkMain("ringL4", 4'b0001, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 4'b0000); checkMain("wrapPulse", 4'b0001, 0, 0);

    // Johnson right through the full eight-state cycle
    applyStimulus(1, 0, 0, 1, 0, 4'b0000); checkMain("john_rst", 4'b0000, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'b0000); checkMain("johnR1", 4'b1000, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'b0000); checkMain("johnR2", 4'b1100, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'b0000); checkMain("johnR3", 4'b1110, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'b0000); checkMain("johnR4", 4'b1111, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'b0000); checkMain("johnR5", 4'b0111, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'b0000); checkMain("johnR6", 4'b0011, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'b0000); checkMain("johnR7", 4'b0001, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'b0000); checkMain("johnR8", 4'b0000, 1, 0);
    applyStimulus(0, 0, 1, 1, 1, 4'b0000); checkMain("johnL1", 4'b0001, 0, 0);
    applyStimulus(0, 0, 1, 1, 1, 4'b0000); checkMain("johnL2", 4'b0011, 0, 0);

    // Illegal ring state after load: correct vs flag-only
    applyStimulus(0, 1, 0, 0, 0, 4'b0110); checkMain("load0110", 4'b0110, 0, 0);
    checkNc("load0110", 4'b0110, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 4'b0000); checkMain("illRing", 4'b0001, 0, 1);
    checkNc("illRing", 4'b0011, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 4'b0000); checkMain("afterFix", 4'b1000, 0, 0);
    checkNc("afterFix", 4'b1001, 0, 1);

    // Mode switch: ring state illegal in Johnson, then legal one
    applyStimulus(0, 1, 0, 0, 0, 4'b0100); checkMain("load0100", 4'b0100, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'b0000); checkMain("swIllegal", 4'b0000, 0, 1);
    checkNc("swIllegal", 4'b1010, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 4'b0001); checkMain("load0001", 4'b0001, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'b0000); checkMain("swLegal", 4'b0000, 1, 0);
    checkNc("swLegal", 4'b0000, 1, 0);

    // Priority: rst over load/en, load over en
    applyStimulus(1, 1, 1, 0, 0, 4'b1010); checkMain("rstWins", 4'b0001, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'b1011); checkMain("loadWins", 4'b1011, 0, 0);
    checkNc("loadWins", 4'b1011, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 4'b0101); checkMain("loadIllJohn", 4'b0101, 0, 0);
    applyStimulus(1, 0, 1, 1, 1, 4'b0000); checkMain("rstJohnMid", 4'b0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule : tb_multimode_ring_counter
